// File: rtl/aes_loopback_checker.sv
// Round-trip checker for AES-over-SPI: per table vector, encrypt on one slave, decrypt on
// the other, compare against the table, and keep run statistics with per-transfer timeouts.
module aes_loopback_checker #(
    parameter int   NUM_VECTORS    = 4,
    parameter int   WAIT_CYCLES    = 70,
    parameter int   TIMEOUT_CYCLES = 4096,
    parameter logic ENC_SEL        = 1'b0,
    parameter logic DEC_SEL        = 1'b1,
    parameter int   IDXW           = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1,
    parameter int   CNTW           = $clog2(NUM_VECTORS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_test,
    input  logic              run_all,
    input  logic [IDXW-1:0]   test_sel,
    output logic [IDXW-1:0]   vec_idx,
    input  logic [1:0]        vec_key_size,
    input  logic [255:0]      vec_key,
    input  logic [127:0]      vec_msg,
    input  logic [127:0]      vec_ct,
    input  logic              vec_ct_chk,
    output logic              spi_sel,
    output logic              spi_start,
    output logic [0:257]      spi_tx,
    input  logic [127:0]      spi_rx,
    input  logic              spi_done,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic [CNTW-1:0]   pass_count,
    output logic [CNTW-1:0]   fail_count,
    output logic [IDXW-1:0]   fail_idx,
    output logic [1:0]        fail_stage,
    output logic [127:0]      last_ct
);

    // state           | meaning
    // IDLE / DONE     | waiting for start_test / one-cycle end of run, pass/fail valid
    // LOAD            | latch the table entry at vec_idx
    // KEY_x/MSG_E/CT_D| SPI write to a slave, spi_start on the first cycle
    // WAIT_x          | slave processing gap of WAIT_CYCLES
    // RECV_x          | SPI read of ciphertext / recovered plaintext
    // CHECK / NEXT    | score the vector / advance or finish
    typedef enum logic [3:0] {
        IDLE, LOAD, KEY_E, MSG_E, WAIT_E, RECV_E,
        KEY_D, CT_D, WAIT_D, RECV_D, CHECK, NEXT, DONE
    } state_t;

    localparam int TMR_MAX = (WAIT_CYCLES > TIMEOUT_CYCLES) ? WAIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TMRW    = $clog2(TMR_MAX + 1);

    state_t            state_q, state_d;
    logic [IDXW-1:0]   vec_idx_q, vec_idx_d;
    logic              run_all_q, run_all_d;
    logic [1:0]        key_size_q, key_size_d;
    logic [255:0]      key_q, key_d;
    logic [127:0]      msg_q, msg_d;
    logic [127:0]      ct_q, ct_d;
    logic              ct_chk_q, ct_chk_d;
    logic              start_q, start_d;
    logic [TMRW-1:0]   tmr_q, tmr_d;
    logic [127:0]      last_ct_q, last_ct_d;
    logic [127:0]      pt_q, pt_d;
    logic              ct_bad_q, ct_bad_d;
    logic [CNTW-1:0]   pass_count_q, pass_count_d;
    logic [CNTW-1:0]   fail_count_q, fail_count_d;
    logic [IDXW-1:0]   fail_idx_q, fail_idx_d;
    logic [1:0]        fail_stage_q, fail_stage_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic              tmr_zero;

    function automatic logic is_xfer(input state_t s);
        return (s == KEY_E) || (s == MSG_E) || (s == RECV_E) ||
               (s == KEY_D) || (s == CT_D)  || (s == RECV_D);
    endfunction

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign tmr_zero = (tmr_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            vec_idx_q    <= '0;
            run_all_q    <= 1'b0;
            key_size_q   <= '0;
            key_q        <= '0;
            msg_q        <= '0;
            ct_q         <= '0;
            ct_chk_q     <= 1'b0;
            start_q      <= 1'b0;
            tmr_q        <= '0;
            last_ct_q    <= '0;
            pt_q         <= '0;
            ct_bad_q     <= 1'b0;
            pass_count_q <= '0;
            fail_count_q <= '0;
            fail_idx_q   <= '0;
            fail_stage_q <= '0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_idx_q    <= vec_idx_d;
            run_all_q    <= run_all_d;
            key_size_q   <= key_size_d;
            key_q        <= key_d;
            msg_q        <= msg_d;
            ct_q         <= ct_d;
            ct_chk_q     <= ct_chk_d;
            start_q      <= start_d;
            tmr_q        <= tmr_d;
            last_ct_q    <= last_ct_d;
            pt_q         <= pt_d;
            ct_bad_q     <= ct_bad_d;
            pass_count_q <= pass_count_d;
            fail_count_q <= fail_count_d;
            fail_idx_q   <= fail_idx_d;
            fail_stage_q <= fail_stage_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        vec_idx_d    = vec_idx_q;
        run_all_d    = run_all_q;
        key_size_d   = key_size_q;
        key_d        = key_q;
        msg_d        = msg_q;
        ct_d         = ct_q;
        ct_chk_d     = ct_chk_q;
        start_d      = 1'b0;
        tmr_d        = tmr_q;
        last_ct_d    = last_ct_q;
        pt_d         = pt_q;
        ct_bad_d     = ct_bad_q;
        pass_count_d = pass_count_q;
        fail_count_d = fail_count_q;
        fail_idx_d   = fail_idx_q;
        fail_stage_d = fail_stage_q;
        pass_d       = pass_q;
        fail_d       = fail_q;

        case (state_q)
            IDLE: begin
                if (start_test) begin
                    state_d      = LOAD;
                    run_all_d    = run_all;
                    vec_idx_d    = run_all ? '0 : test_sel;
                    pass_count_d = '0;
                    fail_count_d = '0;
                    fail_idx_d   = '0;
                    fail_stage_d = 2'd0;
                    pass_d       = 1'b0;
                    fail_d       = 1'b0;
                end
            end
            LOAD: begin
                key_size_d = vec_key_size;
                key_d      = vec_key;
                msg_d      = vec_msg;
                ct_d       = vec_ct;
                ct_chk_d   = vec_ct_chk;
                ct_bad_d   = 1'b0;
                state_d    = KEY_E;
            end
            KEY_E:  if (spi_done) state_d = MSG_E;
            MSG_E:  if (spi_done) state_d = WAIT_E;
            WAIT_E: if (tmr_zero) state_d = RECV_E;
            RECV_E: begin
                if (spi_done) begin
                    last_ct_d = spi_rx;
                    state_d   = KEY_D;
                    // Known-answer miss is recorded now; the decrypt side still runs.
                    if (ct_chk_q && (spi_rx != ct_q)) begin
                        ct_bad_d = 1'b1;
                        if (fail_stage_q == 2'd0) begin
                            fail_idx_d   = vec_idx_q;
                            fail_stage_d = 2'd1;
                        end
                    end
                end
            end
            KEY_D:  if (spi_done) state_d = CT_D;
            CT_D:   if (spi_done) state_d = WAIT_D;
            WAIT_D: if (tmr_zero) state_d = RECV_D;
            RECV_D: begin
                if (spi_done) begin
                    pt_d    = spi_rx;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = NEXT;
                if (ct_bad_q) begin
                    fail_count_d = sat_inc(fail_count_q);
                end else if (pt_q != msg_q) begin
                    fail_count_d = sat_inc(fail_count_q);
                    if (fail_stage_q == 2'd0) begin
                        fail_idx_d   = vec_idx_q;
                        fail_stage_d = 2'd2;
                    end
                end else begin
                    pass_count_d = sat_inc(pass_count_q);
                end
            end
            NEXT: begin
                if (run_all_q && (vec_idx_q < IDXW'(NUM_VECTORS - 1))) begin
                    vec_idx_d = vec_idx_q + 1'b1;
                    state_d   = LOAD;
                end else begin
                    state_d = DONE;
                    pass_d  = (fail_count_q == '0);
                    fail_d  = (fail_count_q != '0);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A done arriving on the expiry cycle wins over the timeout.
        if (is_xfer(state_q) && !spi_done && tmr_zero) begin
            state_d      = DONE;
            fail_count_d = sat_inc(fail_count_q);
            pass_d       = 1'b0;
            fail_d       = 1'b1;
            if (fail_stage_q == 2'd0) begin
                fail_idx_d   = vec_idx_q;
                fail_stage_d = 2'd3;
            end
        end

        if (state_d != state_q) begin
            start_d = is_xfer(state_d);
            tmr_d   = ((state_d == WAIT_E) || (state_d == WAIT_D)) ?
                      TMRW'(WAIT_CYCLES - 1) : TMRW'(TIMEOUT_CYCLES - 1);
        end else if (!tmr_zero) begin
            tmr_d = tmr_q - 1'b1;
        end
    end

    always_comb begin
        spi_sel = 1'b0;
        spi_tx  = '0;
        case (state_q)
            KEY_E:          begin spi_sel = ENC_SEL; spi_tx = {key_size_q, key_q}; end
            MSG_E:          begin spi_sel = ENC_SEL; spi_tx = {130'b0, msg_q}; end
            WAIT_E, RECV_E: spi_sel = ENC_SEL;
            KEY_D:          begin spi_sel = DEC_SEL; spi_tx = {key_size_q, key_q}; end
            CT_D:           begin spi_sel = DEC_SEL; spi_tx = {130'b0, last_ct_q}; end
            WAIT_D, RECV_D: spi_sel = DEC_SEL;
            default: begin
                spi_sel = 1'b0;
                spi_tx  = '0;
            end
        endcase
    end

    assign spi_start  = start_q;
    assign busy       = (state_q != IDLE) && (state_q != DONE);
    assign vec_idx    = vec_idx_q;
    assign pass       = pass_q;
    assign fail       = fail_q;
    assign pass_count = pass_count_q;
    assign fail_count = fail_count_q;
    assign fail_idx   = fail_idx_q;
    assign fail_stage = fail_stage_q;
    assign last_ct    = last_ct_q;

endmodule

// File: tb/tb_aes_loopback_checker.sv
// Directed bench: a behavioural SPI_Main whose slaves answer from a known-answer AES
// table, driven through single, run-all, corrupted, timeout and reset scenarios.
module tb_aes_loopback_checker;
    localparam int NV   = 4;
    localparam int W    = 5;
    localparam int T    = 40;
    localparam int IDXW = 2;
    localparam int CNTW = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_test = 1'b0;
    logic             run_all = 1'b0;
    logic [IDXW-1:0]  test_sel = '0;
    logic [IDXW-1:0]  vec_idx;
    logic [1:0]       vec_key_size;
    logic [255:0]     vec_key;
    logic [127:0]     vec_msg, vec_ct;
    logic             vec_ct_chk;
    logic             spi_sel, spi_start;
    logic [0:257]     spi_tx;
    logic [127:0]     spi_rx;
    logic             spi_done;
    logic             busy, pass, fail;
    logic [CNTW-1:0]  pass_count, fail_count;
    logic [IDXW-1:0]  fail_idx;
    logic [1:0]       fail_stage;
    logic [127:0]     last_ct;

    logic [1:0]   ref_size [NV];
    logic [255:0] ref_key  [NV];
    logic [127:0] ref_msg  [NV];
    logic [127:0] ref_ct   [NV];
    logic [127:0] tab_ct   [NV];

    int errs = 0;
    int checks = 0;

    int           cyc = 0, n_start = 0, n_dec_reads = 0, last_start_cyc = 0, last_done_cyc = 0;
    int           phase [2];
    int           cnt;
    logic [0:257] cap_tx;
    logic         cap_sel, cap_read, pend, stable_ok, prev_start, hang, enc_read_seen;
    logic [127:0] resp;
    logic [1:0]   ssize [2];
    logic [255:0] skey  [2];
    logic [127:0] sdata [2];
    int           idx_log [$];

    assign vec_key_size = ref_size[vec_idx];
    assign vec_key      = ref_key[vec_idx];
    assign vec_msg      = ref_msg[vec_idx];
    assign vec_ct       = tab_ct[vec_idx];
    assign vec_ct_chk   = 1'b1;

    aes_loopback_checker #(
        .NUM_VECTORS(NV), .WAIT_CYCLES(W), .TIMEOUT_CYCLES(T), .ENC_SEL(1'b0), .DEC_SEL(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .start_test(start_test), .run_all(run_all), .test_sel(test_sel),
        .vec_idx(vec_idx), .vec_key_size(vec_key_size), .vec_key(vec_key), .vec_msg(vec_msg),
        .vec_ct(vec_ct), .vec_ct_chk(vec_ct_chk), .spi_sel(spi_sel), .spi_start(spi_start),
        .spi_tx(spi_tx), .spi_rx(spi_rx), .spi_done(spi_done), .busy(busy), .pass(pass),
        .fail(fail), .pass_count(pass_count), .fail_count(fail_count), .fail_idx(fail_idx),
        .fail_stage(fail_stage), .last_ct(last_ct)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [257:0] obs, input logic [257:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave stand-in: an encrypt or decrypt answer is found by table lookup on the true vectors.
    function automatic logic [127:0] slave_resp(input logic sel, input logic [1:0] sz,
                                                input logic [255:0] k, input logic [127:0] d);
        logic [127:0] r;
        r = 128'hbad0bad0bad0bad0bad0bad0bad0bad0;
        for (int i = 0; i < NV; i++) begin
            if (ref_size[i] == sz && ref_key[i] == k) begin
                if (!sel && ref_msg[i] == d) r = ref_ct[i];
                if (sel && ref_ct[i] == d)   r = ref_msg[i];
            end
        end
        return r;
    endfunction

    initial begin
        spi_done = 1'b0; spi_rx = '0; pend = 1'b0; prev_start = 1'b0; hang = 1'b0;
        enc_read_seen = 1'b0; cnt = 0; stable_ok = 1'b1; cap_read = 1'b0; cap_sel = 1'b0;
        cap_tx = '0; resp = '0; phase[0] = 0; phase[1] = 0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            spi_done = 1'b0;
            if (rst) begin
                pend = 1'b0; phase[0] = 0; phase[1] = 0; prev_start = 1'b0;
                continue;
            end
            if (spi_start) begin
                int p;
                n_start++;
                last_start_cyc = cyc;
                chk("start_single", {prev_start, pend}, 2'b00);
                cap_tx = spi_tx; cap_sel = spi_sel; stable_ok = 1'b1; cap_read = 1'b0;
                p = phase[spi_sel];
                if (p == 0) begin
                    ssize[spi_sel] = spi_tx[0:1];
                    skey[spi_sel]  = spi_tx[2:257];
                    if (!spi_sel) idx_log.push_back(int'(vec_idx));
                end else if (p == 1) begin
                    chk("data_frame_pad", spi_tx[0:129], '0);
                    sdata[spi_sel] = spi_tx[130:257];
                end else begin
                    cap_read = 1'b1;
                    chk("read_frame", spi_tx, '0);
                    chk("read_gap", cyc - last_done_cyc, W + 1);
                    if (!spi_sel) enc_read_seen = 1'b1;
                end
                phase[spi_sel] = (p == 2) ? 0 : p + 1;
                resp = slave_resp(spi_sel, ssize[spi_sel], skey[spi_sel], sdata[spi_sel]);
                cnt  = 2 + (n_start % 4);
                pend = !(hang && spi_sel);
            end else if (pend) begin
                if (spi_tx !== cap_tx || spi_sel !== cap_sel) stable_ok = 1'b0;
                if (cnt == 0) begin
                    spi_done = 1'b1; spi_rx = resp; pend = 1'b0; last_done_cyc = cyc;
                    chk("tx_stable", stable_ok, 1'b1);
                    if (cap_sel && cap_read) n_dec_reads++;
                end else begin
                    cnt--;
                end
            end
            prev_start = spi_start;
        end
    end

    task automatic start_run(input logic ra, input logic [IDXW-1:0] sel);
        int v;
        v = ra ? 0 : int'(sel);
        @(negedge clk); run_all = ra; test_sel = sel; start_test = 1'b1;
        @(negedge clk); start_test = 1'b0;
        chk("busy_after_start", busy, 1'b1);
        chk("idx_after_start", vec_idx, v);
        chk("load_no_start", spi_start, 1'b0);
        @(negedge clk);
        chk("first_start", spi_start, 1'b1);
        chk("first_sel", spi_sel, 1'b0);
        chk("first_key_frame", spi_tx, {ref_size[v], ref_key[v]});
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("run_finished", busy, 1'b0);
    endtask

    task automatic chk_reset();
        chk("rst_busy", busy, 1'b0);         chk("rst_pass", pass, 1'b0);
        chk("rst_fail", fail, 1'b0);         chk("rst_pass_count", pass_count, 0);
        chk("rst_fail_count", fail_count, 0); chk("rst_fail_idx", fail_idx, 0);
        chk("rst_fail_stage", fail_stage, 0); chk("rst_last_ct", last_ct, 0);
        chk("rst_vec_idx", vec_idx, 0);       chk("rst_spi_start", spi_start, 1'b0);
        chk("rst_spi_sel", spi_sel, 1'b0);    chk("rst_spi_tx", spi_tx, 0);
    endtask

    initial begin
        int s0, d0;
        ref_size[0] = 2'b00; ref_key[0] = 256'h000102030405060708090a0b0c0d0e0f;
        ref_msg[0]  = 128'h00112233445566778899aabbccddeeff; ref_ct[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        ref_size[1] = 2'b01; ref_key[1] = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
        ref_msg[1]  = 128'h00112233445566778899aabbccddeeff; ref_ct[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        ref_size[2] = 2'b10; ref_key[2] = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        ref_msg[2]  = 128'h00112233445566778899aabbccddeeff; ref_ct[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
        ref_size[3] = 2'b00; ref_key[3] = 256'h2b7e151628aed2a6abf7158809cf4f3c;
        ref_msg[3]  = 128'h3243f6a8885a308d313198a2e0370734; ref_ct[3] = 128'h3925841d02dc09fbdc118597196a0b32;
        for (int i = 0; i < NV; i++) tab_ct[i] = ref_ct[i];

        repeat (3) @(negedge clk);
        chk_reset();
        rst = 1'b0;

        // Single vector, FIPS-197 C.1
        start_run(1'b0, 2'd0);
        wait_idle(1000);
        chk("c1_pass", pass, 1'b1);            chk("c1_fail", fail, 1'b0);
        chk("c1_pass_count", pass_count, 1);   chk("c1_fail_count", fail_count, 0);
        chk("c1_fail_stage", fail_stage, 0);   chk("c1_last_ct", last_ct, ref_ct[0]);
        @(negedge clk);
        chk("c1_pass_sticky", pass, 1'b1);

        // Whole table, with a start_test pulse that must be ignored while busy
        idx_log.delete();
        s0 = n_start;
        start_run(1'b1, 2'd0);
        @(negedge clk); run_all = 1'b0; test_sel = 2'd3; start_test = 1'b1;
        @(negedge clk); start_test = 1'b0;
        chk("busy_pulse_idx", vec_idx, 0);
        wait_idle(3000);
        chk("all_pass", pass, 1'b1);
        chk("all_pass_count", pass_count, 4);  chk("all_fail_count", fail_count, 0);
        chk("all_last_ct", last_ct, ref_ct[3]);
        chk("all_start_count", n_start - s0, 24);
        chk("all_idx_count", idx_log.size(), 4);
        for (int i = 0; i < idx_log.size(); i++) chk("all_idx_seq", idx_log[i], i);

        // Corrupted known answer on vector 2
        tab_ct[2] = ref_ct[2] ^ 128'h1;
        d0 = n_dec_reads;
        start_run(1'b1, 2'd0);
        wait_idle(3000);
        chk("bad_fail", fail, 1'b1);           chk("bad_pass", pass, 1'b0);
        chk("bad_fail_count", fail_count, 1);  chk("bad_pass_count", pass_count, 3);
        chk("bad_fail_idx", fail_idx, 2);      chk("bad_fail_stage", fail_stage, 1);
        chk("bad_dec_reads", n_dec_reads - d0, 4);
        tab_ct[2] = ref_ct[2];

        // Decrypt slave never answers the key write
        hang = 1'b1;
        start_run(1'b0, 2'd0);
        wait_idle(1000);
        chk("to_fail_stage", fail_stage, 3);   chk("to_fail", fail, 1'b1);
        chk("to_pass", pass, 1'b0);            chk("to_fail_count", fail_count, 1);
        chk("to_fail_idx", fail_idx, 0);       chk("to_length", cyc - last_start_cyc, T);
        s0 = n_start;
        repeat (30) @(negedge clk);
        chk("to_no_restart", n_start - s0, 0);
        chk("to_fail_sticky", fail, 1'b1);
        hang = 1'b0;

        // Reset during RECV_E, then a clean rerun
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        enc_read_seen = 1'b0;
        start_run(1'b0, 2'd1);
        for (int i = 0; i < 1000; i++) begin
            if (enc_read_seen) break;
            @(negedge clk);
        end
        chk("recv_e_reached", enc_read_seen, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset();
        rst = 1'b0;
        start_run(1'b0, 2'd1);
        wait_idle(1000);
        chk("rerun_pass", pass, 1'b1);          chk("rerun_pass_count", pass_count, 1);
        chk("rerun_last_ct", last_ct, ref_ct[1]);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errs);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aes_loopback_checker.md
# aes_loopback_checker

Synthesizable, parametrised round-trip checker for the AES-over-SPI subsystem. It drives `SPI_Main` to load a key and plaintext into the encrypt slave and read back the ciphertext, then loads the key and that ciphertext into the decrypt slave and reads back the plaintext. It compares results against a vector table supplied through a lookup port, optionally including a known-answer ciphertext check. It runs one vector or the whole table, keeps pass/fail counters and first-failure diagnostics, and guards every SPI transfer with a timeout.

## Interface
Parameters:
- `NUM_VECTORS`, 4: number of table entries; must be ≥1.
- `WAIT_CYCLES`, 70: idle cycles between a write `spi_done` and the following read `spi_start`.
- `TIMEOUT_CYCLES`, 4096: maximum cycles from `spi_start` to `spi_done`.
- `ENC_SEL`, 0 / `DEC_SEL`, 1: `spi_sel` values for the encrypt and decrypt slaves.
- Derived: `IDXW = max(1, clog2(NUM_VECTORS))`, `CNTW = clog2(NUM_VECTORS+1)`.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start_test` in 1: begins a run when idle; ignored while `busy`.
- `run_all` in 1: sampled with `start_test`. 1 runs vectors 0..NUM_VECTORS-1; 0 runs only `test_sel`.
- `test_sel` in IDXW: vector for single runs; sampled with `start_test`.
- `vec_idx` out IDXW: table address.
- `vec_key_size` in 2: 00=128, 01=192, 10=256.
- `vec_key` in 256: key, right-justified.
- `vec_msg` in 128: plaintext.
- `vec_ct` in 128: expected ciphertext.
- `vec_ct_chk` in 1: 1 enables the known-answer ciphertext compare.
- `spi_sel` out 1, `spi_start` out 1, `spi_tx` out 258 (`[0:257]`, bit 0 MSB): to `SPI_Main`.
- `spi_rx` in 128, `spi_done` in 1: from `SPI_Main`.
- `busy` out 1; `pass` out 1; `fail` out 1.
- `pass_count` out CNTW; `fail_count` out CNTW.
- `fail_idx` out IDXW: first failing vector.
- `fail_stage` out 2: 0 none, 1 ciphertext mismatch, 2 plaintext mismatch, 3 timeout.
- `last_ct` out 128: most recent ciphertext read.

## Operation
- Key frame: `spi_tx = {vec_key_size, vec_key}`. Data frame: `spi_tx = {130'b0, data}`. Read frame: `spi_tx = 0`.
- State flow:
  - IDLE → LOAD on `start_test`. LOAD latches `vec_*` for the current `vec_idx`.
  - Encrypt side, `spi_sel=ENC_SEL`: KEY_E → MSG_E → WAIT_E → RECV_E.
  - Decrypt side, `spi_sel=DEC_SEL`: KEY_D → CT_D → WAIT_D → RECV_D.
  - Then CHECK → NEXT → DONE → IDLE.
- Transfer states (KEY_*, MSG_E, CT_D, RECV_*):
  - `spi_start` is high for exactly the first cycle in the state.
  - `spi_tx` and `spi_sel` are held constant until `spi_done`.
  - `spi_done` advances the state.
- WAIT_* counts WAIT_CYCLES cycles and then advances.
- RECV_E latches `spi_rx` into `last_ct`. If `vec_ct_chk=1` and `last_ct != vec_ct`, the vector fails with stage 1 and the decrypt side still runs.
- CHECK: recovered plaintext `!= vec_msg` fails the vector with stage 2, unless it already failed with stage 1.
- Counting: each vector increments exactly one of `pass_count` or `fail_count`; both saturate at all-ones.
- `fail_idx` and `fail_stage` record the first failure of a run only.
- NEXT: if `run_all=1` and `vec_idx < NUM_VECTORS-1`, increment `vec_idx` and go to LOAD; otherwise go to DONE.
- Timeout: a per-transfer counter reaches TIMEOUT_CYCLES without `spi_done`. Response:
  - stage 3, counted as a fail;
  - the run aborts to DONE;
  - `spi_start` is not reissued.
- DONE, one cycle:
  - `pass = (fail_count==0)`, `fail = ~pass`;
  - `busy` drops;
  - `pass`/`fail` stay sticky until the next accepted `start_test` or `rst`.
- Invalid key size 11 is forwarded unchanged; the slave's behaviour decides the result.

## Timing
- Reset values:
  - all outputs 0, including `spi_tx`, `last_ct`, counters, `fail_stage`;
  - `vec_idx` = 0;
  - state IDLE.
- `rst` mid-run: returns to reset values at the next edge and aborts any transfer. The integrator must also reset `SPI_Main` and the slaves.
- `start_test` sampled high at edge N: `busy`=1 and `vec_idx` valid after N. LOAD occupies N+1. `spi_start`=1 during cycle N+2.
- `vec_*` must be valid by the cycle after `vec_idx` changes; it is combinational-lookup compatible.
- `spi_done` is a one-cycle pulse and is ignored outside transfer states.
- `spi_done` arriving in the same cycle as the timeout expiry counts as done.
- Per-vector overhead beyond SPI time: 2×WAIT_CYCLES + 3 cycles (LOAD, CHECK, NEXT).
- `start_test` held high into DONE/IDLE starts a new run only from IDLE.

## Test plan
- Single vector, FIPS-197 C.1: key 000102…0f, size 00, msg 00112233445566778899aabbccddeeff, `vec_ct_chk`=1, ct 69c4e0d86a7b0430d8cdb78070b4c55a → `pass`=1, `pass_count`=1, `fail_stage`=0, `last_ct` = ct.
- `run_all` over C.1/C.2/C.3 plus a fourth 128-bit vector; expected ct dda97ca4864cdfe06eaf70a0ec0d7191 (192) and 8ea2b7ca516745bfeafc49904b496089 (256) → `pass_count`=4, `vec_idx` sequences 0..3. Check that every `spi_start` is a single cycle, `spi_tx` is stable until done, and the read `spi_start` comes exactly WAIT_CYCLES after the write done.
- Vector 2 with a corrupted `vec_ct` → `fail`=1, `fail_count`=1, `pass_count`=3, `fail_idx`=2, `fail_stage`=1; the decrypt pass still occurs for vector 2.
- Behavioural `SPI_Main` that never returns `spi_done` on KEY_D → after TIMEOUT_CYCLES: `fail_stage`=3, `busy`=0, `fail`=1, no further `spi_start`.
- `rst` asserted during RECV_E → next cycle all outputs are at reset values. A following `start_test` runs cleanly to `pass`=1.
- `start_test` pulsed while `busy` → no effect on counters or `vec_idx`.
